// File: rtl/blake_g_pipe.sv
// Pipelined BLAKE G function for BLAKE-256 (W=32) and BLAKE-512 (W=64).
// Four quarter rounds with register ranks placed by STAGES; valid and tag ride along.
module blake_g_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     msg_i,
  input  logic [W-1:0]     msg_ip,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [W-1:0]     c_out,
  output logic [W-1:0]     d_out,
  output logic [TAG_W-1:0] out_tag
);

  if (!(W == 32 || W == 64)) begin : g_bad_w
    $error("blake_g_pipe: W must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2 || STAGES == 4)) begin : g_bad_stages
    $error("blake_g_pipe: STAGES must be 1, 2 or 4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("blake_g_pipe: TAG_W must be at least 1");
  end

  localparam int R1 = (W == 32) ? 16 : 32;
  localparam int R2 = (W == 32) ? 12 : 25;
  localparam int R3 = (W == 32) ? 8  : 16;
  localparam int R4 = (W == 32) ? 7  : 11;

  // Uniform rank payload; message words are zeroed once consumed so dead bits stay constant.
  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [W-1:0]     d;
    logic [W-1:0]     mi;
    logic [W-1:0]     mip;
  } g_st_t;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int r);
    return (x >> r) | (x << (W - r));
  endfunction

  function automatic g_st_t quarter(input int k, input g_st_t s);
    g_st_t o;
    o = s;
    case (k)
      0: begin
        o.a  = s.a + s.b + s.mi;
        o.d  = rotr(s.d ^ o.a, R1);
        o.mi = '0;
      end
      1: begin
        o.c = s.c + s.d;
        o.b = rotr(s.b ^ o.c, R2);
      end
      2: begin
        o.a   = s.a + s.b + s.mip;
        o.d   = rotr(s.d ^ o.a, R3);
        o.mip = '0;
      end
      default: begin
        o.c = s.c + s.d;
        o.b = rotr(s.b ^ o.c, R4);
      end
    endcase
    return o;
  endfunction

  g_st_t st [5];

  assign st[0] = '{v: in_valid, tag: in_tag, a: a, b: b, c: c, d: d,
                   mi: msg_i, mip: msg_ip};

  for (genvar k = 0; k < 4; k++) begin : g_q
    localparam bit RANK = (STAGES == 4) || (k == 3) || (STAGES == 2 && k == 1);
    g_st_t rank_d;
    assign rank_d = quarter(k, st[k]);
    if (RANK) begin : g_rank
      g_st_t rank_q;
      always_ff @(posedge clk) begin
        if (reset)   rank_q <= '0;
        else if (ce) rank_q <= rank_d;
      end
      assign st[k+1] = rank_q;
    end else begin : g_comb
      assign st[k+1] = rank_d;
    end
  end

  // The last rank always exists, so outputs are registered for every STAGES.
  assign out_valid = st[4].v;
  assign out_tag   = st[4].tag;
  assign a_out     = st[4].a;
  assign b_out     = st[4].b;
  assign c_out     = st[4].c;
  assign d_out     = st[4].d;

  logic unused_msg;
  assign unused_msg = ^{st[4].mi, st[4].mip};

endmodule

// File: tb/tb_blake_g_pipe.sv
// Bench for blake_g_pipe: four instances (W32 x STAGES 1/2/4, W64 x STAGES 4) share stimulus
// and are compared each cycle against a latency-line model built on a plain G reference.
module tb_blake_g_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, in_valid;
  logic [63:0] a_s, b_s, c_s, d_s, mi_s, mip_s;
  logic [7:0]  tag_s;

  logic        ov   [4];
  logic [7:0]  ot   [4];
  logic [255:0] ores [4];
  logic [31:0] r32  [3][4];
  logic [63:0] r64  [4];

  int depth [4] = '{1, 2, 4, 4};
  int wid   [4] = '{32, 32, 32, 64};

  logic         mv [4][4];
  logic [7:0]   mt [4][4];
  logic [255:0] mr [4][4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  blake_g_pipe #(.W(32), .STAGES(1), .TAG_W(8)) u_s1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .a(a_s[31:0]), .b(b_s[31:0]), .c(c_s[31:0]), .d(d_s[31:0]),
    .msg_i(mi_s[31:0]), .msg_ip(mip_s[31:0]), .in_tag(tag_s),
    .out_valid(ov[0]), .a_out(r32[0][0]), .b_out(r32[0][1]), .c_out(r32[0][2]),
    .d_out(r32[0][3]), .out_tag(ot[0]));

  blake_g_pipe #(.W(32), .STAGES(2), .TAG_W(8)) u_s2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .a(a_s[31:0]), .b(b_s[31:0]), .c(c_s[31:0]), .d(d_s[31:0]),
    .msg_i(mi_s[31:0]), .msg_ip(mip_s[31:0]), .in_tag(tag_s),
    .out_valid(ov[1]), .a_out(r32[1][0]), .b_out(r32[1][1]), .c_out(r32[1][2]),
    .d_out(r32[1][3]), .out_tag(ot[1]));

  blake_g_pipe #(.W(32), .STAGES(4), .TAG_W(8)) u_s4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .a(a_s[31:0]), .b(b_s[31:0]), .c(c_s[31:0]), .d(d_s[31:0]),
    .msg_i(mi_s[31:0]), .msg_ip(mip_s[31:0]), .in_tag(tag_s),
    .out_valid(ov[2]), .a_out(r32[2][0]), .b_out(r32[2][1]), .c_out(r32[2][2]),
    .d_out(r32[2][3]), .out_tag(ot[2]));

  blake_g_pipe #(.W(64), .STAGES(4), .TAG_W(8)) u_w64 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .a(a_s), .b(b_s), .c(c_s), .d(d_s), .msg_i(mi_s), .msg_ip(mip_s), .in_tag(tag_s),
    .out_valid(ov[3]), .a_out(r64[0]), .b_out(r64[1]), .c_out(r64[2]),
    .d_out(r64[3]), .out_tag(ot[3]));

  always_comb begin
    for (int u = 0; u < 4; u++) ores[u] = '0;
    for (int u = 0; u < 3; u++)
      ores[u] = {32'b0, r32[u][0], 32'b0, r32[u][1], 32'b0, r32[u][2], 32'b0, r32[u][3]};
    ores[3] = {r64[0], r64[1], r64[2], r64[3]};
  end

  function automatic logic [63:0] rot(logic [63:0] x, int r, int w, logic [63:0] mask);
    return ((x >> r) | (x << (w - r))) & mask;
  endfunction

  // Reference G: returns {a, b, c, d}, each in a 64-bit slot.
  function automatic logic [255:0] g_ref(int w, logic [63:0] a, logic [63:0] b, logic [63:0] c,
                                         logic [63:0] d, logic [63:0] m0, logic [63:0] m1);
    logic [63:0] mask;
    int r1, r2, r3, r4;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (w == 32) begin r1 = 16; r2 = 12; r3 = 8;  r4 = 7;  end
    else         begin r1 = 32; r2 = 25; r3 = 16; r4 = 11; end
    a &= mask; b &= mask; c &= mask; d &= mask; m0 &= mask; m1 &= mask;
    a = (a + b + m0) & mask;
    d = rot(d ^ a, r1, w, mask);
    c = (c + d) & mask;
    b = rot(b ^ c, r2, w, mask);
    a = (a + b + m1) & mask;
    d = rot(d ^ a, r3, w, mask);
    c = (c + d) & mask;
    b = rot(b ^ c, r4, w, mask);
    return {a, b, c, d};
  endfunction

  // Advance one clock; the model sees the same inputs the DUTs sample at this edge.
  task automatic tick();
    for (int u = 0; u < 4; u++) begin
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          mv[u][i] = 1'b0; mt[u][i] = '0; mr[u][i] = '0;
        end
      end else if (ce) begin
        for (int i = 3; i > 0; i--) begin
          mv[u][i] = mv[u][i-1]; mt[u][i] = mt[u][i-1]; mr[u][i] = mr[u][i-1];
        end
        mv[u][0] = in_valid;
        mt[u][0] = tag_s;
        mr[u][0] = g_ref(wid[u], a_s, b_s, c_s, d_s, mi_s, mip_s);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_in();
    a_s   = {$urandom, $urandom}; b_s   = {$urandom, $urandom};
    c_s   = {$urandom, $urandom}; d_s   = {$urandom, $urandom};
    mi_s  = {$urandom, $urandom}; mip_s = {$urandom, $urandom};
    tag_s = 8'($urandom);
  endtask

  task automatic zero_in();
    a_s = '0; b_s = '0; c_s = '0; d_s = '0; mi_s = '0; mip_s = '0; tag_s = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; zero_in();
    tick(); tick();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (ov[u] !== 1'b0 || ot[u] !== 8'h00 || ores[u] !== 256'h0) begin
        failures++;
        $display("FAIL reset_state dut%0d got v=%b tag=%h res=%h want all zero", u, ov[u], ot[u], ores[u]);
      end
    end
    // Fill the pipes, then reset while ce is low.
    reset = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_in(); tick(); end
    ce = 1'b0; reset = 1'b1;
    tick();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (ov[u] !== 1'b0 || ot[u] !== 8'h00 || ores[u] !== 256'h0) begin
        failures++;
        $display("FAIL reset_over_ce dut%0d got v=%b tag=%h res=%h want all zero", u, ov[u], ot[u], ores[u]);
      end
    end
    reset = 1'b0; ce = 1'b1; in_valid = 1'b0; zero_in();
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== 1'b0) begin
          failures++;
          $display("FAIL reset_no_stale dut%0d cyc=%0d got v=%b want 0", u, cyc, ov[u]);
        end
      end
    end
  endtask

  task automatic test_zero_vector();
    zero_in(); tag_s = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; tag_s = 8'h00;
    tick();
    checks++;
    if (ov[1] !== 1'b1 || ot[1] !== 8'h5A || ores[1] !== 256'h0) begin
      failures++;
      $display("FAIL zero_vector got v=%b tag=%h res=%h want v=1 tag=5a res=0", ov[1], ot[1], ores[1]);
    end
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_single_bit();
    logic [255:0] want;
    want = {64'h11, 64'h20220202, 64'h11010100, 64'h11000100};
    zero_in(); mi_s = 64'h1; tag_s = 8'hC3; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_valid = 1'b0;
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== mv[u][depth[u]-1] ||
            (ov[u] && {ot[u], ores[u]} !== {mt[u][depth[u]-1], mr[u][depth[u]-1]})) begin
          failures++;
          $display("FAIL single_bit_model dut%0d k=%0d got v=%b res=%h want v=%b res=%h",
                   u, k, ov[u], ores[u], mv[u][depth[u]-1], mr[u][depth[u]-1]);
        end
      end
      for (int u = 0; u < 3; u++) begin
        if (depth[u] == k) begin
          checks++;
          if (ov[u] !== 1'b1 || ot[u] !== 8'hC3 || ores[u] !== want) begin
            failures++;
            $display("FAIL single_bit dut%0d k=%0d got v=%b tag=%h res=%h want v=1 tag=c3 res=%h",
                     u, k, ov[u], ot[u], ores[u], want);
          end
        end
      end
    end
  endtask

  task automatic test_streaming();
    int seen;
    seen = 0;
    in_valid = 1'b1; ce = 1'b1;
    for (int n = 0; n < 1004; n++) begin
      if (n < 1000) rand_in(); else in_valid = 1'b0;
      tick();
      if (ov[3] === 1'b1) seen++;
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== mv[u][depth[u]-1] ||
            (ov[u] && {ot[u], ores[u]} !== {mt[u][depth[u]-1], mr[u][depth[u]-1]})) begin
          failures++;
          $display("FAIL stream dut%0d cyc=%0d got v=%b tag=%h res=%h want v=%b tag=%h res=%h",
                   u, cyc, ov[u], ot[u], ores[u], mv[u][depth[u]-1], mt[u][depth[u]-1], mr[u][depth[u]-1]);
        end
      end
    end
    checks++;
    if (seen !== 1000) begin
      failures++;
      $display("FAIL stream_count got %0d results want 1000", seen);
    end
  endtask

  task automatic test_stall();
    for (int n = 0; n < 604; n++) begin
      if (n < 600) begin
        rand_in();
        ce = ($urandom_range(0, 9) >= 3);
        in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        ce = 1'b1; in_valid = 1'b0;
      end
      tick();
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== mv[u][depth[u]-1] ||
            (ov[u] && {ot[u], ores[u]} !== {mt[u][depth[u]-1], mr[u][depth[u]-1]})) begin
          failures++;
          $display("FAIL stall dut%0d cyc=%0d got v=%b tag=%h res=%h want v=%b tag=%h res=%h",
                   u, cyc, ov[u], ot[u], ores[u], mv[u][depth[u]-1], mt[u][depth[u]-1], mr[u][depth[u]-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    ce = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (n < 20) begin
        rand_in();
        a_s = '1; b_s = '1; mi_s = '1; in_valid = 1'b1;
      end else in_valid = 1'b0;
      tick();
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== mv[u][depth[u]-1] ||
            (ov[u] && {ot[u], ores[u]} !== {mt[u][depth[u]-1], mr[u][depth[u]-1]})) begin
          failures++;
          $display("FAIL wrap dut%0d cyc=%0d got v=%b res=%h want v=%b res=%h",
                   u, cyc, ov[u], ores[u], mv[u][depth[u]-1], mr[u][depth[u]-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int hits, at;
    hits = 0; at = -1;
    ce = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin rand_in(); tick(); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (ov[u] !== 1'b0 || ot[u] !== 8'h00 || ores[u] !== 256'h0) begin
        failures++;
        $display("FAIL midflight_reset dut%0d got v=%b tag=%h res=%h want all zero", u, ov[u], ot[u], ores[u]);
      end
    end
    reset = 1'b0; rand_in(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (ov[2] === 1'b1) begin hits++; at = k; end
      for (int u = 0; u < 4; u++) begin
        checks++;
        if (ov[u] !== mv[u][depth[u]-1] ||
            (ov[u] && {ot[u], ores[u]} !== {mt[u][depth[u]-1], mr[u][depth[u]-1]})) begin
          failures++;
          $display("FAIL midflight dut%0d k=%0d got v=%b res=%h want v=%b res=%h",
                   u, k, ov[u], ores[u], mv[u][depth[u]-1], mr[u][depth[u]-1]);
        end
      end
    end
    checks++;
    if (hits !== 1 || at !== 3) begin
      failures++;
      $display("FAIL midflight_latency got hits=%0d at=%0d want hits=1 at=3 (4th edge incl. accept)", hits, at);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0;
    a_s = '0; b_s = '0; c_s = '0; d_s = '0; mi_s = '0; mip_s = '0; tag_s = '0;
    for (int u = 0; u < 4; u++)
      for (int i = 0; i < 4; i++) begin
        mv[u][i] = 1'b0; mt[u][i] = '0; mr[u][i] = '0;
      end
    test_reset();
    test_zero_vector();
    test_single_bit();
    test_streaming();
    test_stall();
    test_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blake_g_pipe.md
# blake_g_pipe

Parametrised, pipelined BLAKE G-function core for the unrolled round datapath. It takes one (a, b, c, d) column or diagonal quadruple plus two pre-whitened message words per cycle and produces the updated quadruple after a fixed latency. The core serves both BLAKE-256 (W=32) and BLAKE-512 (W=64) and has a selectable register depth, so place-and-route can trade area against Fmax. A valid bit, a user tag and a global clock enable travel through every rank, so the round chain can stall and track nonces without external bookkeeping.

## Interface
- W, 32: word width; legal values 32 or 64 only; any other value is an elaboration error.
- STAGES, 2: number of register ranks; legal values 1, 2 or 4; latency equals STAGES.
- TAG_W, 8: width of the sideband tag carried alongside the data; minimum 1.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; all ranks hold when low.
- in_valid  in  1  input quadruple is valid this cycle.
- a, b, c, d  in  W each  state words in.
- msg_i  in  W  first message word, already XORed with its constant.
- msg_ip  in  W  second message word, already XORed; sampled in the same cycle as msg_i.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output quadruple valid.
- a_out, b_out, c_out, d_out  out  W each  updated state words.
- out_tag  out  TAG_W  tag that entered with this result.

## Operation
- Rotation amounts are rotate-right values: R1..R4 = 16, 12, 8, 7 when W=32, and 32, 25, 16, 11 when W=64.
- Every add is modulo 2^W and carries are discarded. The three-input adds may use a carry-save form, but the result must be bit-identical.
- The function is split into four quarters:
  - Q1: a1 = a+b+msg_i; d1 = rotr(d^a1, R1).
  - Q2: c1 = c+d1; b1 = rotr(b^c1, R2).
  - Q3: a2 = a1+b1+msg_ip; d2 = rotr(d1^a2, R3).
  - Q4: c2 = c1+d2; b2 = rotr(b1^c2, R4).
- Outputs: a_out = a2, b_out = b2, c_out = c2, d_out = d2.
- Rank placement:
  - STAGES=1: one rank after Q4.
  - STAGES=2: ranks after Q2 and after Q4.
  - STAGES=4: a rank after each quarter.
- Outputs are always registered; there is no combinational path from input to output.
- Every live intermediate is carried in each rank together with a valid bit and the tag, including msg_ip until Q3 and any of a, b, c, d not yet consumed.
- When ce=1, every rank loads from its predecessor regardless of valid. A bubble (in_valid=0) propagates as out_valid=0 with don't-care data; the bench compares data only when out_valid=1.
- When ce=0, every rank holds, including valid and tag bits.

## Timing
- Latency: a sample taken at a ce=1 edge appears on the outputs after STAGES ce=1 edges. Throughput is one result per ce=1 cycle.
- Reset values: out_valid=0, a_out/b_out/c_out/d_out=0, out_tag=0, and every internal rank cleared to 0.
- Priority: reset overrides ce. Reset while ce=0 still clears all ranks.
- Reset mid-stream: all in-flight results are discarded and no stale out_valid follows. The first input accepted in the cycle after reset deasserts emerges STAGES ce-cycles later.
- ce toggling: results are neither lost nor duplicated; out_valid stays high during a hold if it was high.
- Back-to-back valid inputs with no bubbles produce back-to-back valid outputs in the same order, each with its own tag.

## Test plan
- Zero vector, W=32, STAGES=2: all inputs 0, in_valid=1, tag 0x5A -> 2 cycles later out_valid=1, all outputs 0, out_tag=0x5A.
- Single bit, W=32, every STAGES value: a=b=c=d=0, msg_i=1, msg_ip=0 -> a_out=0x00000011, d_out=0x11000100, c_out=0x11010100, b_out=0x20220202 after 1, 2 and 4 cycles respectively.
- Streaming: 1000 random back-to-back vectors with random tags, W=32 and W=64, checked against a software G model -> exact match, in order, no gaps.
- Stall: random ce pattern with about 30% low, interleaved bubbles -> same output sequence as the ce=1 run; outputs held stable while ce=0.
- Reset mid-flight, STAGES=4: three valid inputs, assert reset for one cycle, then one new input -> no out_valid for the flushed inputs; the new result appears 4 cycles after acceptance; all outputs read 0 during and after reset.
- Wrap-around, W=64: a=b=msg_i=0xFFFFFFFFFFFFFFFF with the remaining inputs random -> result matches the model with carries discarded.
